// File: rtl/melody_pkg.sv
// -----------------------------------------------------------------------------
// melody_pkg
// Shared definitions for the melody sequencer: pitch codes, the 50 MHz
// half-period table, the note entry layout, the song ROM and FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package melody_pkg;

   localparam int HP_W = 17;   // widest half-period (C4 = 95556) needs 17 bits

   localparam logic [3:0] PITCH_REST = 4'd0;
   localparam logic [3:0] PITCH_C4   = 4'd1;
   localparam logic [3:0] PITCH_D4   = 4'd2;
   localparam logic [3:0] PITCH_E4   = 4'd3;
   localparam logic [3:0] PITCH_F4   = 4'd4;
   localparam logic [3:0] PITCH_G4   = 4'd5;
   localparam logic [3:0] PITCH_A4   = 4'd6;
   localparam logic [3:0] PITCH_B4   = 4'd7;
   localparam logic [3:0] PITCH_C5   = 4'd8;
   localparam logic [3:0] PITCH_D5   = 4'd9;
   localparam logic [3:0] PITCH_E5   = 4'd10;
   localparam logic [3:0] PITCH_F5   = 4'd11;
   localparam logic [3:0] PITCH_G5   = 4'd12;
   localparam logic [3:0] PITCH_A5   = 4'd13;
   localparam logic [3:0] PITCH_B5   = 4'd14;
   localparam logic [3:0] PITCH_END  = 4'd15;

   // osc clocks per half cycle of each pitch at 50 MHz; rest/end entries are unused
   localparam logic [HP_W-1:0] HALF_PERIOD [0:15] = '{
      17'd0,     17'd95556, 17'd85131, 17'd75843, 17'd71586, 17'd63776,
      17'd56818, 17'd50619, 17'd47778, 17'd42566, 17'd37922, 17'd35793,
      17'd31888, 17'd28409, 17'd25310, 17'd0
   };

   typedef struct packed {
      logic [3:0] pitch;
      logic [3:0] dur;     // note lasts (dur+1) ticks
   } note_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP
   } state_t;

   localparam note_t SONG [0:15] = '{
      {PITCH_C4, 4'd3}, {PITCH_E4, 4'd3}, {PITCH_G4, 4'd3}, {PITCH_REST, 4'd1},
      {PITCH_C5, 4'd7}, {PITCH_END, 4'd0}, {PITCH_D4, 4'd1}, {PITCH_F4, 4'd1},
      {PITCH_A4, 4'd1}, {PITCH_B4, 4'd1}, {PITCH_D5, 4'd1}, {PITCH_E5, 4'd1},
      {PITCH_F5, 4'd1}, {PITCH_G5, 4'd1}, {PITCH_A5, 4'd1}, {PITCH_B5, 4'd1}
   };

   // Scaled half-period; never below 2 so the tone divider always has a full step.
   function automatic logic [HP_W-1:0] half_period(input logic [3:0] pitch,
                                                   input int unsigned shift);
      logic [HP_W-1:0] hp;
      hp = HALF_PERIOD[pitch] >> shift;
      if (hp < 17'd2) hp = 17'd2;
      return hp;
   endfunction

   // Entries past the physical table read as an end marker.
   function automatic note_t song_entry(input int unsigned idx);
      note_t n;
      n = {PITCH_END, 4'd0};
      if (idx < 32'd16) n = SONG[idx[3:0]];
      return n;
   endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// -----------------------------------------------------------------------------
// melody_sequencer_if
// Control/status bundle of the melody sequencer.
//   start, stop : controller -> sequencer
//   buzzer      : tone output to the piezo pin
//   busy, done  : playback status (done is a one-cycle pulse)
//   note_idx    : index of the current song entry
// Modports: master = surrounding control logic, slave = melody_sequencer.
// -----------------------------------------------------------------------------
interface melody_sequencer_if #(parameter int IDX_W = 4);
   logic             start;
   logic             stop;
   logic             buzzer;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] note_idx;

   modport master (output start, output stop,
                   input buzzer, input busy, input done, input note_idx);
   modport slave  (input start, input stop,
                   output buzzer, output busy, output done, output note_idx);
endinterface

// File: rtl/melody_sequencer_tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Programmable half-period square-wave divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : clear the counter and start the wave high
//   enable     : run the divider; output forced low when clear
//   hp         : half-period in clocks (>= 2)
//   buzzer     : square-wave output
// -----------------------------------------------------------------------------
module tone_gen
   import melody_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            restart,
   input  logic            enable,
   input  logic [HP_W-1:0] hp,
   output logic            buzzer
);

   logic [HP_W-1:0] cnt_reg;
   logic            out_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         out_reg <= 1'b0;
      end else if (restart) begin
         cnt_reg <= '0;
         out_reg <= 1'b1;
      end else if (enable) begin
         if (cnt_reg == hp - HP_W'(1)) begin
            cnt_reg <= '0;
            out_reg <= ~out_reg;
         end else begin
            cnt_reg <= cnt_reg + HP_W'(1);
         end
      end
   end

   // Gating is combinational so a stop or note change silences the pin at once.
   assign buzzer = out_reg & enable;

endmodule

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
// Steps through the song ROM in melody_pkg, playing each entry through
// tone_gen for (dur+1)*TICK_DIV clocks, separated by a 1-clock LOAD.
//   osc   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : melody_sequencer_if.slave (start, stop, buzzer, busy, done, note_idx)
// Build option: define MELODY_GAP_EN to insert a silent gap of
// GAP_TICKS*TICK_DIV clocks after every note (GAP_TICKS must be >= 1).
// -----------------------------------------------------------------------------
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int TICK_DIV  = 5_000_000,
   parameter int HP_SHIFT  = 0,
   parameter int SONG_LEN  = 16,
   parameter int GAP_TICKS = 1
)
(
   input  logic                  osc,
   input  logic                  rst_n,
   melody_sequencer_if.slave     bus
);

   localparam int IDX_W = $clog2(SONG_LEN);
   // One counter times both notes (up to 16 ticks) and gaps.
   localparam int DUR_MAX = TICK_DIV * ((GAP_TICKS > 16) ? GAP_TICKS : 16);
   localparam int DUR_W   = $clog2(DUR_MAX);
   // Index carries one extra bit so it can reach SONG_LEN itself.
   localparam logic [IDX_W:0] SONG_END = (IDX_W+1)'(SONG_LEN);

   state_t            state_reg, state_next;
   logic [IDX_W:0]    idx_reg, idx_next;
   logic [DUR_W-1:0]  dur_reg, dur_next;
   logic [HP_W-1:0]   hp_reg, hp_next;
   logic              done_reg, done_next;
   logic              tone_restart;
   logic              tone_en;
   logic              tone_out;
   note_t             cur_note;
   logic              at_end;

   always_comb begin
      cur_note = song_entry(32'(idx_reg));
      at_end   = (cur_note.pitch == PITCH_END) || (idx_reg == SONG_END);
   end

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         dur_reg   <= '0;
         hp_reg    <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         dur_reg   <= dur_next;
         hp_reg    <= hp_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      dur_next     = dur_reg;
      hp_next      = hp_reg;
      done_next    = 1'b0;
      tone_restart = 1'b0;
      if (bus.stop) begin
         // stop beats start and suppresses done; the index is left as is
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  idx_next   = '0;
                  state_next = ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (at_end) begin
                  done_next  = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  hp_next      = half_period(cur_note.pitch, HP_SHIFT);
                  dur_next     = DUR_W'((int'(cur_note.dur) + 1) * TICK_DIV - 1);
                  tone_restart = 1'b1;
                  state_next   = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (dur_reg == '0) begin
`ifdef MELODY_GAP_EN
                  dur_next   = DUR_W'(GAP_TICKS * TICK_DIV - 1);
                  state_next = ST_GAP;
`else
                  idx_next   = idx_reg + 1'b1;
                  state_next = ST_LOAD;
`endif
               end else begin
                  dur_next = dur_reg - 1'b1;
               end
            end
            ST_GAP: begin
`ifdef MELODY_GAP_EN
               if (dur_reg == '0) begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = ST_LOAD;
               end else begin
                  dur_next = dur_reg - 1'b1;
               end
`else
               state_next = ST_IDLE;   // unreachable without the gap option
`endif
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Rests keep the divider disabled, so the pin stays low for the whole note.
   assign tone_en = (state_reg == ST_PLAY) && (cur_note.pitch != PITCH_REST);

   tone_gen u_tone_gen (
      .clk     (osc),
      .rst_n   (rst_n),
      .restart (tone_restart),
      .enable  (tone_en),
      .hp      (hp_reg),
      .buzzer  (tone_out)
   );

   assign bus.buzzer   = tone_out;
   assign bus.busy     = (state_reg != ST_IDLE);
   assign bus.done     = done_reg;
   assign bus.note_idx = idx_reg[IDX_W-1:0];

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
// Directed bench for melody_sequencer with TICK_DIV=10, HP_SHIFT=12.
// A timeline model derives busy/buzzer/done/note_idx from the song table and
// is compared every cycle; literal expectations at key cycles pin the model.
// Honours MELODY_GAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;
   import melody_pkg::*;

   localparam int TD = 10;
   localparam int HS = 12;
   localparam int SL = 16;
   localparam int GT = 1;
`ifdef MELODY_GAP_EN
   localparam int G       = GT * TD;
   localparam int E42_IDX = 0;    // cycle 42 is inside the first gap
`else
   localparam int G       = 0;
   localparam int E42_IDX = 1;    // cycle 42 is the LOAD of entry 1
`endif
   localparam int SLOT     = 41 + G;        // slot of a dur=3 note
   localparam int DONE_CYC = 227 + 5 * G;   // cycle where done pulses

   logic clk = 1'b0;
   logic rst_n;
   int   tot = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   m_act;
   int   m_t;
   int   m_idx;

   melody_sequencer_if #(.IDX_W(4)) bus ();

   melody_sequencer #(
      .TICK_DIV  (TD),
      .HP_SHIFT  (HS),
      .SONG_LEN  (SL),
      .GAP_TICKS (GT)
   ) dut (
      .osc   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   // Outputs at cycle t after the start edge (t=1 is the first LOAD).
   function automatic void tl(input int t, output bit b, output bit z,
                              output bit d, output int ix);
      int off;
      off = 1;
      b = 0; z = 0; d = 0; ix = 0;
      for (int i = 0; i <= SL; i++) begin
         note_t n;
         int    len;
         int    hp;
         ix = i;
         if (i < 16 && i < SL) n = SONG[i];
         else n = {PITCH_END, 4'd0};
         if (n.pitch == PITCH_END || i == SL) begin
            if (t == off) b = 1;
            else if (t == off + 1) d = 1;
            return;
         end
         if (t == off) begin
            b = 1;
            return;
         end
         len = (int'(n.dur) + 1) * TD;
         if (t <= off + len) begin
            b  = 1;
            hp = int'(HALF_PERIOD[n.pitch]) >> HS;
            if (hp < 2) hp = 2;
            if (n.pitch != PITCH_REST) z = (((t - off - 1) / hp) % 2) == 0;
            return;
         end
         if (t <= off + len + G) begin
            b = 1;
            return;
         end
         off = off + 1 + len + G;
      end
   endfunction

   function automatic void cur_exp(output bit b, output bit z, output bit d, output int ix);
      if (m_act) begin
         tl(m_t, b, z, d, ix);
      end else begin
         b = 0; z = 0; d = 0; ix = m_idx;
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   // Advance the model on the inputs the DUT sees at this edge.
   task automatic model_update();
      bit b, z, d;
      int ix;
      if (!rst_n) begin
         m_act = 0; m_t = 0; m_idx = 0;
      end else begin
         cur_exp(b, z, d, ix);
         if (bus.stop) begin
            m_act = 0;
            m_idx = ix;
         end else if (bus.start && !b) begin
            m_act = 1;
            m_t   = 1;
         end else if (m_act) begin
            m_t++;
         end
      end
   endtask

   task automatic model_check();
      bit b, z, d;
      int ix;
      if (!rst_n) begin
         b = 0; z = 0; d = 0; ix = 0;
      end else begin
         cur_exp(b, z, d, ix);
      end
      chk("model_busy",   32'(bus.busy),     32'(b));
      chk("model_buzzer", 32'(bus.buzzer),   32'(z));
      chk("model_done",   32'(bus.done),     32'(d));
      chk("model_idx",    32'(bus.note_idx), 32'(ix));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #3;
      cyc++;
      model_check();
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      rst_n     = 1'b0;
      m_act = 0; m_t = 0; m_idx = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      $display("reset released: busy=%0d buzzer=%0d idx=%0d", bus.busy, bus.buzzer, bus.note_idx);
      chk("rst_busy",   32'(bus.busy),     32'd0);
      chk("rst_buzzer", 32'(bus.buzzer),   32'd0);
      chk("rst_done",   32'(bus.done),     32'd0);
      chk("rst_idx",    32'(bus.note_idx), 32'd0);

      // full song
      $display("start: play song from entry 0");
      bus.start = 1'b1; cyc = 0; tick(); bus.start = 1'b0;
      chk("load_busy",   32'(bus.busy),   32'd1);
      chk("load_buzzer", 32'(bus.buzzer), 32'd0);
      goto(2);  chk("c4_rise",   32'(bus.buzzer), 32'd1);
      goto(24); chk("c4_hi_end", 32'(bus.buzzer), 32'd1);
      goto(25); chk("c4_fall",   32'(bus.buzzer), 32'd0);
      goto(42); chk("c42_idx",   32'(bus.note_idx), 32'(E42_IDX));
                chk("c42_buz",   32'(bus.buzzer),   32'd0);
      goto(1 + SLOT);      chk("e4_load_idx", 32'(bus.note_idx), 32'd1);
      goto(2 + SLOT);      chk("e4_rise",     32'(bus.buzzer),   32'd1);
      goto(2 + SLOT + 17); chk("e4_hi_end",   32'(bus.buzzer),   32'd1);
      goto(2 + SLOT + 18); chk("e4_fall",     32'(bus.buzzer),   32'd0);
      goto(2 + 2 * SLOT + 5);
      $display("start while busy at cyc=%0d idx=%0d", cyc, bus.note_idx);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      chk("busy_start_idx", 32'(bus.note_idx), 32'd2);
      goto(2 + 2 * SLOT + 14); chk("g4_hi_end", 32'(bus.buzzer), 32'd1);
      goto(2 + 2 * SLOT + 15); chk("g4_fall",   32'(bus.buzzer), 32'd0);
      goto(130 + 3 * G);
      chk("rest_buzzer", 32'(bus.buzzer),   32'd0);
      chk("rest_busy",   32'(bus.busy),     32'd1);
      chk("rest_idx",    32'(bus.note_idx), 32'd3);
      goto(DONE_CYC - 1); chk("end_load_busy", 32'(bus.busy), 32'd1);
                          chk("end_load_done", 32'(bus.done), 32'd0);
      goto(DONE_CYC);
      $display("song end at cyc=%0d done=%0d busy=%0d", cyc, bus.done, bus.busy);
      chk("done_pulse",  32'(bus.done),     32'd1);
      chk("done_busy",   32'(bus.busy),     32'd0);
      chk("done_buzzer", 32'(bus.buzzer),   32'd0);
      chk("done_idx",    32'(bus.note_idx), 32'd5);
      goto(DONE_CYC + 1); chk("done_single", 32'(bus.done), 32'd0);

      // stop during entry 1
      $display("start then stop during entry 1");
      bus.start = 1'b1; cyc = 0; tick(); bus.start = 1'b0;
      goto(2 + SLOT + 3); chk("pre_stop_buz", 32'(bus.buzzer), 32'd1);
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
      chk("stop_buzzer", 32'(bus.buzzer),   32'd0);
      chk("stop_busy",   32'(bus.busy),     32'd0);
      chk("stop_done",   32'(bus.done),     32'd0);
      chk("stop_idx",    32'(bus.note_idx), 32'd1);
      repeat (5) tick();

      // start and stop together while idle
      $display("start+stop together while idle");
      bus.start = 1'b1; bus.stop = 1'b1; tick();
      bus.start = 1'b0; bus.stop = 1'b0;
      chk("ss_busy", 32'(bus.busy),     32'd0);
      chk("ss_idx",  32'(bus.note_idx), 32'd1);
      repeat (3) tick();

      // reset in the middle of a note
      $display("start then reset mid-note");
      bus.start = 1'b1; cyc = 0; tick(); bus.start = 1'b0;
      goto(2 + SLOT + 5);
      chk("pre_rst_buz", 32'(bus.buzzer),   32'd1);
      chk("pre_rst_idx", 32'(bus.note_idx), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_buzzer", 32'(bus.buzzer),   32'd0);
      chk("arst_busy",   32'(bus.busy),     32'd0);
      chk("arst_idx",    32'(bus.note_idx), 32'd0);
      chk("arst_done",   32'(bus.done),     32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("post_rst_busy", 32'(bus.busy),   32'd0);
      chk("post_rst_buz",  32'(bus.buzzer), 32'd0);
      $display("restart after reset");
      bus.start = 1'b1; cyc = 0; tick(); bus.start = 1'b0;
      goto(2); chk("restart_rise", 32'(bus.buzzer), 32'd1);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
